flag_capture_detector: RTL and testbench

- Consumer end of the flag object interface. Samples the flag position/size bus and the player box once per frame. Decides when the player has captured the flag.
- Then animates the flag sliding down the pole and raises a level-done request to the top-level game FSM, held until acknowledged.
- Sits between the flag/player motion modules and the game-state controller. Runs on the system clock and treats frame_clk as a sampled input.

---
 rtl/flag_pkg.sv | 29 ++
 rtl/frame_tick_sync.sv | 29 ++
 rtl/flag_capture_detector.sv | 190 +++++++++++++++++++
 tb/tb_flag_capture_detector.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/flag_pkg.sv
// Shared definitions for the flag capture path: FSM encoding, coordinate width,
// default flag geometry and an absolute-difference helper.
package flag_pkg;

    localparam int unsigned COORD_W = 10;
    localparam int unsigned DIFF_W  = COORD_W + 1;

    localparam int unsigned FLAG_X_DEF = 575;
    localparam int unsigned FLAG_Y_DEF = 245;
    localparam int unsigned FLAG_W_DEF = 44;
    localparam int unsigned FLAG_H_DEF = 40;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SEEK  = 3'd1,
        ST_HOLD  = 3'd2,
        ST_LOWER = 3'd3,
        ST_DONE  = 3'd4
    } flag_state_e;

    // |a - b| computed on one extra bit so the difference never wraps
    function automatic logic [DIFF_W-1:0] abs_diff(input logic [COORD_W-1:0] a,
                                                   input logic [COORD_W-1:0] b);
        logic [DIFF_W-1:0] d;
        d = DIFF_W'(a) - DIFF_W'(b);
        return d[DIFF_W-1] ? (~d + DIFF_W'(1)) : d;
    endfunction

endpackage

// File: rtl/frame_tick_sync.sv
// Brings the frame clock into the Clk domain: two-flop synchronizer plus an
// edge register; o_frame_tick_c pulses one cycle per frame_clk rise.
module frame_tick_sync (
    input  logic Clk,
    input  logic Reset_n,
    input  logic i_frame_clk,
    output logic o_frame_tick_c
);

    logic r_sync1;
    logic r_sync2;
    logic r_sync_prev;

    // Synchronizer chain and previous-value register for edge detection
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_sync1     <= 1'b0;
            r_sync2     <= 1'b0;
            r_sync_prev <= 1'b0;
        end else begin
            r_sync1     <= i_frame_clk;
            r_sync2     <= r_sync1;
            r_sync_prev <= r_sync2;
        end
    end

    assign o_frame_tick_c = r_sync2 & ~r_sync_prev;

endmodule

// File: rtl/flag_capture_detector.sv
// Flag capture detector: per-frame overlap test between player and flag boxes,
// capture commit after HOLD_FRAMES consecutive overlaps, flag-lowering
// animation and a level-done request held until acknowledged.
// Optional: define FLAG_TIMER_EN to add the capture_time frame counter output.
module flag_capture_detector
    import flag_pkg::*;
#(
    parameter int unsigned HOLD_FRAMES = 4,
    parameter int unsigned DROP_STEP   = 2,
    parameter int unsigned DROP_MAX    = 120
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               frame_clk,
    input  logic               enable,
    input  logic [COORD_W-1:0] FlagX,
    input  logic [COORD_W-1:0] FlagY,
    input  logic [COORD_W-1:0] FlagWidth,
    input  logic [COORD_W-1:0] FlagHeight,
    input  logic [COORD_W-1:0] PlayerX,
    input  logic [COORD_W-1:0] PlayerY,
    input  logic [COORD_W-1:0] PlayerS,
    output logic               captured,
    output logic [COORD_W-1:0] FlagDropY,
    output logic               done_req,
    input  logic               done_ack,
    output logic [2:0]         state_o
`ifdef FLAG_TIMER_EN
    ,
    output logic [15:0]        capture_time
`endif
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned TMR_W = 16;

    flag_state_e        r_state,    w_state_nxt;
    logic [CNT_W-1:0]   r_hold_cnt, w_cnt_nxt;
    logic               r_captured, w_captured_nxt;
    logic [COORD_W-1:0] r_drop,     w_drop_nxt;
    logic               r_done_req, w_done_nxt;
    logic [TMR_W-1:0]   r_timer,    w_timer_nxt;

    logic               w_tick;
    logic [DIFF_W-1:0]  w_adx, w_ady, w_thx, w_thy;
    logic               w_overlap;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic [DIFF_W-1:0]  w_drop_sum;
    logic [COORD_W-1:0] w_drop_sat;
    logic [TMR_W-1:0]   w_timer_inc;

    frame_tick_sync u_tick (
        .Clk            (Clk),
        .Reset_n        (Reset_n),
        .i_frame_clk    (frame_clk),
        .o_frame_tick_c (w_tick)
    );

    // Strict box overlap on 11-bit magnitudes; touching edges do not count
    always_comb begin
        w_adx     = abs_diff(PlayerX, FlagX);
        w_ady     = abs_diff(PlayerY, FlagY);
        w_thx     = DIFF_W'(PlayerS) + DIFF_W'(FlagWidth  >> 1);
        w_thy     = DIFF_W'(PlayerS) + DIFF_W'(FlagHeight >> 1);
        w_overlap = (w_adx < w_thx) && (w_ady < w_thy);
    end

    // Saturating arithmetic shared by the FSM
    always_comb begin
        w_cnt_inc   = r_hold_cnt + CNT_W'(1);
        w_drop_sum  = DIFF_W'(r_drop) + DIFF_W'(DROP_STEP);
        w_drop_sat  = (w_drop_sum >= DIFF_W'(DROP_MAX)) ? COORD_W'(DROP_MAX)
                                                        : w_drop_sum[COORD_W-1:0];
        w_timer_inc = (r_timer == {TMR_W{1'b1}}) ? r_timer : r_timer + TMR_W'(1);
    end

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_hold_cnt;
        w_captured_nxt = r_captured;
        w_drop_nxt     = r_drop;
        w_done_nxt     = r_done_req;
        w_timer_nxt    = r_timer;
        case (r_state)
            ST_IDLE: begin
                if (enable) begin
                    w_state_nxt = ST_SEEK;
                    w_cnt_nxt   = '0;
                    w_timer_nxt = '0;
                end
            end
            ST_SEEK: begin
                if (!enable) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else if (w_tick) begin
                    w_timer_nxt = w_timer_inc;
                    if (w_overlap) begin
                        w_cnt_nxt = CNT_W'(1);
                        if (HOLD_FRAMES == 1) begin
                            w_state_nxt    = ST_LOWER;
                            w_captured_nxt = 1'b1;
                        end else begin
                            w_state_nxt = ST_HOLD;
                        end
                    end
                end
            end
            ST_HOLD: begin
                if (!enable) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else if (w_tick) begin
                    w_timer_nxt = w_timer_inc;
                    if (w_overlap) begin
                        w_cnt_nxt = w_cnt_inc;
                        if (w_cnt_inc == CNT_W'(HOLD_FRAMES)) begin
                            w_state_nxt    = ST_LOWER;
                            w_captured_nxt = 1'b1;
                        end
                    end else begin
                        w_state_nxt = ST_SEEK;
                        w_cnt_nxt   = '0;
                    end
                end
            end
            ST_LOWER: begin
                if (w_tick) begin
                    w_drop_nxt = w_drop_sat;
                    if (w_drop_sat == COORD_W'(DROP_MAX)) begin
                        w_state_nxt = ST_DONE;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                w_done_nxt = 1'b1;
                if (done_ack) begin
                    w_state_nxt    = ST_IDLE;
                    w_done_nxt     = 1'b0;
                    w_captured_nxt = 1'b0;
                    w_drop_nxt     = '0;
                    w_cnt_nxt      = '0;
                    w_timer_nxt    = '0;
                end
            end
            default: begin
                w_state_nxt    = ST_IDLE;
                w_cnt_nxt      = '0;
                w_captured_nxt = 1'b0;
                w_drop_nxt     = '0;
                w_done_nxt     = 1'b0;
                w_timer_nxt    = '0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_state    <= ST_IDLE;
            r_hold_cnt <= '0;
            r_captured <= 1'b0;
            r_drop     <= '0;
            r_done_req <= 1'b0;
            r_timer    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_hold_cnt <= w_cnt_nxt;
            r_captured <= w_captured_nxt;
            r_drop     <= w_drop_nxt;
            r_done_req <= w_done_nxt;
            r_timer    <= w_timer_nxt;
        end
    end

    assign state_o   = r_state;
    assign captured  = r_captured;
    assign FlagDropY = r_drop;
    assign done_req  = r_done_req;

`ifdef FLAG_TIMER_EN
    assign capture_time = r_timer;
`else
    logic w_timer_unused;
    assign w_timer_unused = ^r_timer;
`endif

endmodule

// File: tb/tb_flag_capture_detector.sv
// Directed bench for flag_capture_detector with hand-computed expectations.
module tb_flag_capture_detector;
    import flag_pkg::*;

    logic               Clk = 1'b0;
    logic               Reset_n;
    logic               frame_clk;
    logic               enable;
    logic [COORD_W-1:0] FlagX, FlagY, FlagWidth, FlagHeight;
    logic [COORD_W-1:0] PlayerX, PlayerY, PlayerS;
    logic               captured;
    logic [COORD_W-1:0] FlagDropY;
    logic               done_req;
    logic               done_ack;
    logic [2:0]         state_o;
`ifdef FLAG_TIMER_EN
    logic [15:0]        capture_time;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    flag_capture_detector dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .frame_clk  (frame_clk),
        .enable     (enable),
        .FlagX      (FlagX),
        .FlagY      (FlagY),
        .FlagWidth  (FlagWidth),
        .FlagHeight (FlagHeight),
        .PlayerX    (PlayerX),
        .PlayerY    (PlayerY),
        .PlayerS    (PlayerS),
        .captured   (captured),
        .FlagDropY  (FlagDropY),
        .done_req   (done_req),
        .done_ack   (done_ack),
        .state_o    (state_o)
`ifdef FLAG_TIMER_EN
        ,
        .capture_time (capture_time)
`endif
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic set_player(input int x, input int y);
        PlayerX = COORD_W'(x);
        PlayerY = COORD_W'(y);
    endtask

    // One frame_clk period; the FSM reacts on the third rising Clk edge
    task automatic frame();
        frame_clk = 1'b1;
        cycles(4);
        frame_clk = 1'b0;
        cycles(4);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_state"},    int'(state_o),   0);
        check({tag, "_captured"}, int'(captured),  0);
        check({tag, "_drop"},     int'(FlagDropY), 0);
        check({tag, "_done"},     int'(done_req),  0);
    endtask

    task automatic do_reset();
        Reset_n = 1'b0;
        cycles(3);
        check_idle_outputs("reset");
        Reset_n = 1'b1;
    endtask

    initial begin
        Reset_n    = 1'b0;
        frame_clk  = 1'b0;
        enable     = 1'b0;
        done_ack   = 1'b0;
        FlagX      = COORD_W'(FLAG_X_DEF);
        FlagY      = COORD_W'(FLAG_Y_DEF);
        FlagWidth  = COORD_W'(FLAG_W_DEF);
        FlagHeight = COORD_W'(FLAG_H_DEF);
        PlayerS    = COORD_W'(8);
        set_player(100, 100);
        @(negedge Clk);
        do_reset();

        // Capture with |dx|=25 < 30, including commit latency
        enable = 1'b1;
        cycles(1);
        check("enter_seek", int'(state_o), 1);
        done_ack = 1'b1;
        cycles(1);
        done_ack = 1'b0;
        check("ack_ignored_seek", int'(state_o), 1);
        set_player(550, 245);
        for (int f = 1; f <= 3; f++) begin
            frame();
            check("hold_state", int'(state_o), 2);
            check("hold_not_captured", int'(captured), 0);
        end
        frame_clk = 1'b1;
        cycles(2);
        check("commit_latency_pre", int'(captured), 0);
        cycles(1);
        check("commit_latency", int'(captured), 1);
        check("commit_state", int'(state_o), 3);
        cycles(1);
        frame_clk = 1'b0;
        cycles(4);

        // Lowering: 2,4,...,120; enable drop part way is ignored
        for (int k = 1; k <= 60; k++) begin
            if (k == 10) enable = 1'b0;
            frame();
            check("drop_step", int'(FlagDropY), 2 * k);
        end
        check("done_state", int'(state_o), 4);
        check("done_req_set", int'(done_req), 1);
        for (int c = 0; c < 5; c++) begin
            cycles(1);
            check("done_req_hold", int'(done_req), 1);
        end
        check("captured_in_done", int'(captured), 1);
        done_ack = 1'b1;
        cycles(1);
        done_ack = 1'b0;
        check_idle_outputs("ack");

        // Touching edge |dx|=30: no capture over 10 frames
        enable = 1'b1;
        cycles(1);
        set_player(545, 245);
        for (int f = 0; f < 10; f++) frame();
        check("edge_x_state", int'(state_o), 1);
        check("edge_x_captured", int'(captured), 0);

        // Vertical boundary: |dy|=28 misses, |dy|=27 overlaps
        set_player(575, 217);
        frame();
        check("edge_y_miss", int'(state_o), 1);
        set_player(575, 218);
        frame();
        check("edge_y_hit", int'(state_o), 2);
        set_player(545, 245);
        frame();
        check("miss_to_seek", int'(state_o), 1);

        // 3 hits, 1 miss, 4 hits -> capture only on frame 8
        set_player(550, 245);
        for (int f = 0; f < 3; f++) frame();
        check("pat_hold3", int'(state_o), 2);
        set_player(600, 300);
        frame();
        check("pat_miss_seek", int'(state_o), 1);
        set_player(550, 245);
        for (int f = 0; f < 3; f++) frame();
        check("pat_frame7_state", int'(state_o), 2);
        check("pat_frame7_captured", int'(captured), 0);
        frame();
        check("pat_frame8_captured", int'(captured), 1);
        check("pat_frame8_state", int'(state_o), 3);

        // Reset in the middle of LOWER
        for (int f = 0; f < 5; f++) frame();
        check("mid_lower_drop", int'(FlagDropY), 10);
        do_reset();

        // enable dropped in HOLD clears the hold count
        enable = 1'b1;
        cycles(1);
        for (int f = 0; f < 2; f++) frame();
        check("hold_before_drop", int'(state_o), 2);
        enable = 1'b0;
        cycles(1);
        check("enable_drop_idle", int'(state_o), 0);
        enable = 1'b1;
        cycles(1);
        for (int f = 0; f < 3; f++) frame();
        check("recount_hold", int'(state_o), 2);
        check("recount_not_captured", int'(captured), 0);
        frame();
        check("recount_captured", int'(captured), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
